// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM states, per-cycle action and strobe bundle.
// decode_act() resolves the per-cycle priority between memory wait, flush and stall.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StFreeze   = 2'd1,
    StRedirect = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    ActNormal = 2'd0,
    ActFreeze = 2'd1,
    ActFlush  = 2'd2,
    ActStall  = 2'd3
  } pipe_act_t;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_clr;
    logic de_en;
    logic de_clr;
    logic em_en;
    logic mw_en;
  } strobe_t;

  // A frozen state with memory ready again behaves as RUN, so only REDIRECT masks stall.
  function automatic pipe_act_t decode_act(pipe_state_t state, logic mem_ready, logic flush,
                                           logic stall);
    pipe_act_t act;
    if (!mem_ready) begin
      act = ActFreeze;
    end else if (flush) begin
      act = ActFlush;
    end else if (stall && (state != StRedirect)) begin
      act = ActStall;
    end else begin
      act = ActNormal;
    end
    return act;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-unit requests in, pipeline-register strobes, valids and perf counters out.
// master = the driving side (hazard unit / bench), slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned CntW = 32
);
  logic            stall;
  logic            flush;
  logic [1:0]      pc_sel_in;
  logic            mem_ready;
  logic            cnt_clr;
  logic            pc_en;
  logic [1:0]      pc_sel;
  logic            fd_en;
  logic            fd_clr;
  logic            de_en;
  logic            de_clr;
  logic            em_en;
  logic            mw_en;
  logic            d_valid;
  logic            e_valid;
  logic            m_valid;
  logic            w_valid;
  logic            rf_we_en;
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;
  logic            stall_err;

  modport master (
    output stall, flush, pc_sel_in, mem_ready, cnt_clr,
    input  pc_en, pc_sel, fd_en, fd_clr, de_en, de_clr, em_en, mw_en,
    input  d_valid, e_valid, m_valid, w_valid, rf_we_en, stall_cnt, flush_cnt, stall_err
  );

  modport slave (
    input  stall, flush, pc_sel_in, mem_ready, cnt_clr,
    output pc_en, pc_sel, fd_en, fd_clr, de_en, de_clr, em_en, mw_en,
    output d_valid, e_valid, m_valid, w_valid, rf_we_en, stall_cnt, flush_cnt, stall_err
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment in the same cycle.
module pipe_ctrl_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Turns hazard-unit stall/flush/pc_sel into pipeline-register strobes and stage valids, with a
// whole-pipe freeze on memory wait, stall/flush counters and a consecutive-stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CntW     = 32,
  parameter int unsigned MaxStall = 2
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned WdW = $clog2(MaxStall + 1);
  localparam logic [WdW-1:0] StallLimit = WdW'(MaxStall);

  pipe_state_t    state_q, state_d;
  logic           d_valid_q, d_valid_d;
  logic           e_valid_q, e_valid_d;
  logic           m_valid_q, m_valid_d;
  logic           w_valid_q, w_valid_d;
  logic [WdW-1:0] stall_run_q, stall_run_d;
  logic           stall_err_q, stall_err_d;
  pipe_act_t      act;
  strobe_t        strobe;
  logic [1:0]     pc_sel;

  assign act = decode_act(state_q, bus.mem_ready, bus.flush, bus.stall);

  // Strobes act in the same cycle; reset forces a safe, bubble-inserting pattern.
  always_comb begin
    strobe = '0;
    pc_sel = bus.pc_sel_in;
    unique case (act)
      ActNormal: begin
        strobe.pc_en = 1'b1;
        strobe.fd_en = 1'b1;
        strobe.de_en = 1'b1;
        strobe.em_en = 1'b1;
        strobe.mw_en = 1'b1;
      end
      ActFreeze: strobe = '0;
      ActFlush: begin
        strobe.pc_en  = 1'b1;
        strobe.fd_clr = 1'b1;
        strobe.de_clr = 1'b1;
        strobe.em_en  = 1'b1;
        strobe.mw_en  = 1'b1;
      end
      ActStall: begin
        strobe.de_clr = 1'b1;
        strobe.em_en  = 1'b1;
        strobe.mw_en  = 1'b1;
      end
      default: strobe = '0;
    endcase
    if (!rst_n) begin
      strobe        = '0;
      strobe.fd_clr = 1'b1;
      strobe.de_clr = 1'b1;
      pc_sel        = 2'b00;
    end
  end

  always_comb begin
    state_d     = state_q;
    d_valid_d   = d_valid_q;
    e_valid_d   = e_valid_q;
    m_valid_d   = m_valid_q;
    w_valid_d   = w_valid_q;
    stall_run_d = stall_run_q;
    stall_err_d = stall_err_q;
    unique case (act)
      ActNormal: begin
        state_d     = StRun;
        d_valid_d   = 1'b1;
        e_valid_d   = d_valid_q;
        m_valid_d   = e_valid_q;
        w_valid_d   = m_valid_q;
        stall_run_d = '0;
      end
      ActFreeze: state_d = StFreeze;
      ActFlush: begin
        state_d     = StRedirect;
        d_valid_d   = 1'b0;
        e_valid_d   = 1'b0;
        m_valid_d   = e_valid_q;
        w_valid_d   = m_valid_q;
        stall_run_d = '0;
      end
      ActStall: begin
        state_d   = StRun;
        e_valid_d = 1'b0;
        m_valid_d = e_valid_q;
        w_valid_d = m_valid_q;
        if (stall_run_q != StallLimit) begin
          stall_run_d = stall_run_q + WdW'(1);
        end
      end
      default: state_d = StRun;
    endcase
    if (stall_run_d == StallLimit) begin
      stall_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      d_valid_q   <= 1'b0;
      e_valid_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      w_valid_q   <= 1'b0;
      stall_run_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_valid_q   <= d_valid_d;
      e_valid_q   <= e_valid_d;
      m_valid_q   <= m_valid_d;
      w_valid_q   <= w_valid_d;
      stall_run_q <= stall_run_d;
      stall_err_q <= stall_err_d;
    end
  end

  pipe_ctrl_sat_counter #(
    .W(CntW)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(bus.cnt_clr),
    .inc_i(act == ActStall),
    .cnt_o(bus.stall_cnt)
  );

  pipe_ctrl_sat_counter #(
    .W(CntW)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(bus.cnt_clr),
    .inc_i(act == ActFlush),
    .cnt_o(bus.flush_cnt)
  );

  assign bus.pc_en     = strobe.pc_en;
  assign bus.pc_sel    = pc_sel;
  assign bus.fd_en     = strobe.fd_en;
  assign bus.fd_clr    = strobe.fd_clr;
  assign bus.de_en     = strobe.de_en;
  assign bus.de_clr    = strobe.de_clr;
  assign bus.em_en     = strobe.em_en;
  assign bus.mw_en     = strobe.mw_en;
  assign bus.d_valid   = d_valid_q;
  assign bus.e_valid   = e_valid_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.w_valid   = w_valid_q;
  assign bus.rf_we_en  = w_valid_q & bus.mem_ready;
  assign bus.stall_err = stall_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change on the falling edge, outputs are checked there.
module tb_pipe_ctrl;

  localparam int unsigned CntW = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  pipe_ctrl_if #(.CntW(CntW)) bus ();

  pipe_ctrl #(
    .CntW    (CntW),
    .MaxStall(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ens();
    return {bus.pc_en, bus.fd_en, bus.de_en, bus.em_en, bus.mw_en};
  endfunction

  function automatic logic [3:0] vals();
    return {bus.d_valid, bus.e_valid, bus.m_valid, bus.w_valid};
  endfunction

  task automatic idle_inputs();
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.pc_sel_in = 2'b01;
    bus.mem_ready = 1'b1;
    bus.cnt_clr   = 1'b0;
  endtask

  // Reset, release, then five idle cycles so every stage is valid.
  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    bus.pc_sel_in = 2'b11;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ens() !== 5'b00000) $display("FAIL reset_ens: got %b want 00000", ens());
    else n_pass++;
    n_total++;
    if ({bus.fd_clr, bus.de_clr} !== 2'b11)
      $display("FAIL reset_clr: got %b want 11", {bus.fd_clr, bus.de_clr});
    else n_pass++;
    n_total++;
    if (bus.pc_sel !== 2'b00) $display("FAIL reset_pc_sel: got %b want 00", bus.pc_sel);
    else n_pass++;
    n_total++;
    if ({vals(), bus.stall_cnt, bus.flush_cnt, bus.stall_err} !== 13'd0)
      $display("FAIL reset_state: got %b want 0", {vals(), bus.stall_cnt, bus.flush_cnt,
                                                    bus.stall_err});
    else n_pass++;
    @(negedge clk);
    bus.pc_sel_in = 2'b01;
    rst_n = 1'b1;
    #1;
    n_total++;
    if ({ens(), bus.fd_clr, bus.de_clr, bus.pc_sel} !== 9'b11111_00_01)
      $display("FAIL release_strobes: got %b want 111110001",
               {ens(), bus.fd_clr, bus.de_clr, bus.pc_sel});
    else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      logic [3:0] exp_v;
      @(negedge clk);
      exp_v = (k == 1) ? 4'b1000 : (k == 2) ? 4'b1100 : (k == 3) ? 4'b1110 : 4'b1111;
      n_total++;
      if (vals() !== exp_v || bus.fd_en !== 1'b1)
        $display("FAIL fill_cycle%0d: got v=%b fd_en=%b want v=%b fd_en=1", k, vals(),
                 bus.fd_en, exp_v);
      else n_pass++;
    end
    n_total++;
    if (bus.rf_we_en !== 1'b1) $display("FAIL fill_rf_we: got %b want 1", bus.rf_we_en);
    else n_pass++;
  endtask

  task automatic test_stall();
    reset_dut();
    bus.stall = 1'b1;
    #1;
    n_total++;
    if ({ens(), bus.fd_clr, bus.de_clr} !== 7'b00011_01)
      $display("FAIL stall_strobes: got %b want 0001101", {ens(), bus.fd_clr, bus.de_clr});
    else n_pass++;
    @(negedge clk);
    bus.stall = 1'b0;
    n_total++;
    if (vals() !== 4'b1011 || bus.stall_cnt !== 4'd1 || bus.stall_err !== 1'b0)
      $display("FAIL stall_after: got v=%b cnt=%0d err=%b want v=1011 cnt=1 err=0", vals(),
               bus.stall_cnt, bus.stall_err);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (vals() !== 4'b1101) $display("FAIL stall_bubble: got %b want 1101", vals());
    else n_pass++;
  endtask

  task automatic test_flush_stall();
    reset_dut();
    bus.flush     = 1'b1;
    bus.stall     = 1'b1;
    bus.pc_sel_in = 2'b10;
    #1;
    n_total++;
    if ({ens(), bus.fd_clr, bus.de_clr, bus.pc_sel} !== 9'b10011_11_10)
      $display("FAIL flush_strobes: got %b want 100111110",
               {ens(), bus.fd_clr, bus.de_clr, bus.pc_sel});
    else n_pass++;
    @(negedge clk);
    bus.flush = 1'b0;
    n_total++;
    if (vals() !== 4'b0011 || bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0)
      $display("FAIL flush_after: got v=%b fc=%0d sc=%0d want v=0011 fc=1 sc=0", vals(),
               bus.flush_cnt, bus.stall_cnt);
    else n_pass++;
    #1;
    n_total++;
    if ({ens(), bus.de_clr} !== 6'b11111_0)
      $display("FAIL redirect_ignores_stall: got %b want 111110", {ens(), bus.de_clr});
    else n_pass++;
    @(negedge clk);
    bus.stall = 1'b0;
    n_total++;
    if (vals() !== 4'b1001 || bus.stall_cnt !== 4'd0)
      $display("FAIL redirect_after: got v=%b sc=%0d want v=1001 sc=0", vals(), bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_freeze();
    reset_dut();
    bus.mem_ready = 1'b0;
    bus.flush     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++;
      if ({ens(), bus.fd_clr, bus.de_clr, bus.rf_we_en} !== 8'b0)
        $display("FAIL freeze_strobes%0d: got %b want 00000000", c,
                 {ens(), bus.fd_clr, bus.de_clr, bus.rf_we_en});
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (vals() !== 4'b1111 || bus.flush_cnt !== 4'd0)
      $display("FAIL freeze_hold: got v=%b fc=%0d want v=1111 fc=0", vals(), bus.flush_cnt);
    else n_pass++;
    bus.mem_ready = 1'b1;
    #1;
    n_total++;
    if ({bus.pc_en, bus.fd_clr, bus.de_clr} !== 3'b111)
      $display("FAIL unfreeze_flush: got %b want 111", {bus.pc_en, bus.fd_clr, bus.de_clr});
    else n_pass++;
    @(negedge clk);
    bus.flush = 1'b0;
    n_total++;
    if (vals() !== 4'b0011 || bus.flush_cnt !== 4'd1)
      $display("FAIL unfreeze_after: got v=%b fc=%0d want v=0011 fc=1", vals(), bus.flush_cnt);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    reset_dut();
    bus.stall = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.stall_err !== 1'b0) $display("FAIL wd_first: got %b want 0", bus.stall_err);
    else n_pass++;
    @(negedge clk);
    bus.stall = 1'b0;
    n_total++;
    if (bus.stall_err !== 1'b1) $display("FAIL wd_second: got %b want 1", bus.stall_err);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.stall_err !== 1'b1) $display("FAIL wd_sticky: got %b want 1", bus.stall_err);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.stall_err !== 1'b0) $display("FAIL wd_reset: got %b want 0", bus.stall_err);
    else n_pass++;
    // Run count must survive a freeze between two stalls.
    reset_dut();
    bus.stall = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.stall = 1'b0;
    n_total++;
    if (bus.stall_err !== 1'b1 || bus.stall_cnt !== 4'd2)
      $display("FAIL wd_freeze_hold: got err=%b sc=%0d want err=1 sc=2", bus.stall_err,
               bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    reset_dut();
    bus.stall = 1'b1;
    repeat (15) @(negedge clk);
    n_total++;
    if (bus.stall_cnt !== 4'hF) $display("FAIL sat_reach: got %0d want 15", bus.stall_cnt);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.stall_cnt !== 4'hF) $display("FAIL sat_hold: got %0d want 15", bus.stall_cnt);
    else n_pass++;
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    bus.stall   = 1'b0;
    n_total++;
    if (bus.stall_cnt !== 4'd0) $display("FAIL clr_priority: got %0d want 0", bus.stall_cnt);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_stall();
    test_flush_stall();
    test_freeze();
    test_watchdog();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
